// File: rtl/snn_multi_core_out_collector.sv
// Output/tick hub for an N-core SNN grid.
// Each core's output packets are buffered in a small per-core FIFO. A
// round-robin arbiter moves at most one packet per cycle into a merged
// fall-through FIFO and tags it with the source core ID. A three-state FSM
// releases a requested global tick once every core is ready and every
// per-core channel has drained.
module snn_multi_core_out_collector #(
  parameter int  NUM_CORES = 4,
  parameter int  PKT_W     = 8,
  parameter int  CH_ASIZE  = 2,
  parameter int  OUT_ASIZE = 6,
  localparam int ID_W      = $clog2(NUM_CORES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CORES-1:0]       core_pkt_valid,
  input  logic [NUM_CORES*PKT_W-1:0] core_pkt_data,
  input  logic [NUM_CORES-1:0]       core_tick_ready,
  input  logic                       tick_in,
  output logic                       tick_out,
  output logic                       tick_overrun,
  input  logic                       out_rinc,
  output logic [ID_W+PKT_W-1:0]      out_rdata,
  output logic                       out_rempty,
  output logic [OUT_ASIZE:0]         out_count,
  output logic [NUM_CORES-1:0]       ch_overflow,
  input  logic                       clear_errors
);

  localparam int CH_DEPTH  = 1 << CH_ASIZE;
  localparam int OUT_DEPTH = 1 << OUT_ASIZE;
  localparam int OUT_W     = ID_W + PKT_W;

  localparam logic [CH_ASIZE:0]  CH_ONE  = 1;
  localparam logic [OUT_ASIZE:0] OUT_ONE = 1;
  localparam logic [ID_W-1:0]    ID_ONE  = 1;
  localparam logic [ID_W-1:0]    ID_LAST = ID_W'(NUM_CORES - 1);

  // Per-core channel storage; pointers carry an extra MSB for full detection.
  logic [PKT_W-1:0]     ch_mem  [NUM_CORES][CH_DEPTH];
  logic [CH_ASIZE:0]    ch_wptr [NUM_CORES];
  logic [CH_ASIZE:0]    ch_rptr [NUM_CORES];
  logic [NUM_CORES-1:0] ch_empty;
  logic [NUM_CORES-1:0] ch_full;
  logic [NUM_CORES-1:0] ch_push;
  logic [NUM_CORES-1:0] ch_pop;
  logic [NUM_CORES-1:0] ovf_evt;

  // Arbiter: rr_ptr is the first channel examined in the next search.
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;
  logic             grant;
  logic [PKT_W-1:0] grant_pkt;

  // Merged fall-through FIFO.
  logic [OUT_W-1:0]   out_mem [OUT_DEPTH];
  logic [OUT_ASIZE:0] out_wptr;
  logic [OUT_ASIZE:0] out_rptr;
  logic               out_full;
  logic               out_pop;

  // Tick sequencer.
  typedef enum logic [1:0] {TICK_IDLE, TICK_WAIT, TICK_ISSUE} tick_state_t;
  tick_state_t tick_state;
  tick_state_t tick_state_nxt;
  logic        overrun_evt;

  // Channel status; a full channel rejects a write even when it is popped.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      ch_empty[i] = (ch_wptr[i] == ch_rptr[i]);
      ch_full[i]  = (ch_wptr[i][CH_ASIZE] != ch_rptr[i][CH_ASIZE]) &&
                    (ch_wptr[i][CH_ASIZE-1:0] == ch_rptr[i][CH_ASIZE-1:0]);
    end
    ch_push = core_pkt_valid & ~ch_full;
    ovf_evt = core_pkt_valid & ch_full;
  end

  // Round-robin search for the first non-empty channel from rr_ptr.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_CORES);
      if (!grant_vld && !ch_empty[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
    // Space is judged on the registered count; a same-cycle pop does not help.
    grant  = grant_vld && !out_full;
    ch_pop = '0;
    if (grant) ch_pop[grant_id] = 1'b1;
    grant_pkt = ch_mem[grant_id][ch_rptr[grant_id][CH_ASIZE-1:0]];
  end

  // Channel pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        ch_wptr[i] <= '0;
        ch_rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (ch_push[i]) ch_wptr[i] <= ch_wptr[i] + CH_ONE;
        if (ch_pop[i])  ch_rptr[i] <= ch_rptr[i] + CH_ONE;
      end
    end
  end

  // Channel data storage (not reset; pointers define validity).
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (ch_push[i]) ch_mem[i][ch_wptr[i][CH_ASIZE-1:0]] <= core_pkt_data[i*PKT_W +: PKT_W];
    end
  end

  // Merged FIFO status and fall-through head; head reads zero while empty.
  always_comb begin
    out_count  = out_wptr - out_rptr;
    out_full   = out_count[OUT_ASIZE];
    out_rempty = (out_wptr == out_rptr);
    out_pop    = out_rinc && !out_rempty;
    out_rdata  = out_rempty ? '0 : out_mem[out_rptr[OUT_ASIZE-1:0]];
  end

  // Merged FIFO pointers and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wptr <= '0;
      out_rptr <= '0;
      rr_ptr   <= '0;
    end else begin
      if (grant) begin
        out_wptr <= out_wptr + OUT_ONE;
        rr_ptr   <= (grant_id == ID_LAST) ? '0 : grant_id + ID_ONE;
      end
      if (out_pop) out_rptr <= out_rptr + OUT_ONE;
    end
  end

  // Merged FIFO storage: {source core ID, packet}.
  always_ff @(posedge clk) begin
    if (grant) out_mem[out_wptr[OUT_ASIZE-1:0]] <= {grant_id, grant_pkt};
  end

  // Tick FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_state <= TICK_IDLE;
    else       tick_state <= tick_state_nxt;
  end

  // Tick FSM next state, Moore tick output and overrun detection.
  always_comb begin
    tick_state_nxt = tick_state;
    tick_out       = 1'b0;
    overrun_evt    = 1'b0;
    case (tick_state)
      TICK_IDLE: begin
        if (tick_in) tick_state_nxt = TICK_WAIT;
      end
      TICK_WAIT: begin
        overrun_evt = tick_in;
        if (&core_tick_ready && &ch_empty) tick_state_nxt = TICK_ISSUE;
      end
      TICK_ISSUE: begin
        tick_out       = 1'b1;
        overrun_evt    = tick_in;
        tick_state_nxt = TICK_IDLE;
      end
      default: tick_state_nxt = TICK_IDLE;
    endcase
  end

  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_overrun <= 1'b0;
      ch_overflow  <= '0;
    end else begin
      tick_overrun <= (tick_overrun && !clear_errors) || overrun_evt;
      ch_overflow  <= (ch_overflow & ~{NUM_CORES{clear_errors}}) | ovf_evt;
    end
  end

endmodule

// File: tb/tb_snn_multi_core_out_collector.sv
// Bench for snn_multi_core_out_collector: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_snn_multi_core_out_collector;

  localparam int NC  = 4;
  localparam int PW  = 8;
  localparam int CHD = 4;
  localparam int OD  = 64;
  localparam int IDW = 2;
  localparam int OW  = IDW + PW;
  localparam logic [13:0] RST_CTL = 14'h0080;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NC-1:0]    core_pkt_valid = '0;
  logic [NC*PW-1:0] core_pkt_data = '0;
  logic [NC-1:0]    core_tick_ready = '1;
  logic             tick_in = 1'b0;
  logic             tick_out;
  logic             tick_overrun;
  logic             out_rinc = 1'b0;
  logic [OW-1:0]    out_rdata;
  logic             out_rempty;
  logic [6:0]       out_count;
  logic [NC-1:0]    ch_overflow;
  logic             clear_errors = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snn_multi_core_out_collector dut (
    .clk            (clk),
    .reset          (reset),
    .core_pkt_valid (core_pkt_valid),
    .core_pkt_data  (core_pkt_data),
    .core_tick_ready(core_tick_ready),
    .tick_in        (tick_in),
    .tick_out       (tick_out),
    .tick_overrun   (tick_overrun),
    .out_rinc       (out_rinc),
    .out_rdata      (out_rdata),
    .out_rempty     (out_rempty),
    .out_count      (out_count),
    .ch_overflow    (ch_overflow),
    .clear_errors   (clear_errors)
  );

  // Reference model: packet queues, next search start, tick phase, error flags.
  logic [PW-1:0] m_ch [NC][$];
  logic [OW-1:0] m_out[$];
  int            m_next;
  bit            m_wait, m_issue, m_overrun;
  logic [NC-1:0] m_ovf;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_ch[i].delete();
    m_out.delete();
    m_next = 0; m_wait = 0; m_issue = 0; m_overrun = 0; m_ovf = '0;
  endtask

  task automatic model_update();
    int   pre_size[NC];
    int   out_size;
    bit   all_empty, ovr;
    int   g, j;
    logic [PW-1:0] pkt;
    out_size  = m_out.size();
    all_empty = 1;
    for (int i = 0; i < NC; i++) begin
      pre_size[i] = m_ch[i].size();
      if (pre_size[i] != 0) all_empty = 0;
    end
    ovr = tick_in && (m_wait || m_issue);
    if (m_issue) m_issue = 0;
    else if (m_wait) begin
      if (&core_tick_ready && all_empty) begin m_wait = 0; m_issue = 1; end
    end else if (tick_in) m_wait = 1;
    if (clear_errors) begin m_overrun = 0; m_ovf = '0; end
    if (ovr) m_overrun = 1;
    g = -1;
    if (out_size < OD)
      for (int k = 0; k < NC; k++) begin
        j = (m_next + k) % NC;
        if (g < 0 && pre_size[j] > 0) g = j;
      end
    if (out_rinc && out_size > 0) void'(m_out.pop_front());
    if (g >= 0) begin
      pkt = m_ch[g].pop_front();
      m_out.push_back({g[IDW-1:0], pkt});
      m_next = (g + 1) % NC;
    end
    for (int i = 0; i < NC; i++)
      if (core_pkt_valid[i]) begin
        if (pre_size[i] >= CHD) m_ovf[i] = 1'b1;
        else m_ch[i].push_back(core_pkt_data[i*PW +: PW]);
      end
  endtask

  function automatic logic [13:0] exp_ctl();
    logic [6:0] c;
    c = 7'(m_out.size());
    return {m_issue, m_overrun, m_ovf, (m_out.size() == 0), c};
  endfunction

  function automatic logic [OW-1:0] exp_head();
    return (m_out.size() > 0) ? m_out[0] : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) model_reset(); else model_update();
    #1;
  endtask

  task automatic idle_inputs();
    core_pkt_valid = '0; core_pkt_data = '0; core_tick_ready = '1;
    tick_in = 0; out_rinc = 0; clear_errors = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    step(); step();
    n_checks++;
    if ({tick_out, tick_overrun, ch_overflow, out_rempty, out_count} !== RST_CTL || out_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ctl=%h rdata=%h, want ctl=%h rdata=0",
               {tick_out, tick_overrun, ch_overflow, out_rempty, out_count}, out_rdata, RST_CTL);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    core_pkt_valid = 4'b0100; core_pkt_data = 32'h00A5_0000;
    step();
    core_pkt_valid = '0;
    n_checks++;
    if (out_rempty !== 1'b1) begin
      n_fail++; $display("FAIL single_cycle1_empty: got %b, want 1", out_rempty);
    end
    step();
    n_checks++;
    if (out_rempty !== 1'b0 || out_rdata !== 10'h2A5 || out_count !== 7'd1) begin
      n_fail++;
      $display("FAIL single_cycle2: got empty=%b rdata=%h count=%0d, want 0 2a5 1", out_rempty, out_rdata, out_count);
    end
    out_rinc = 1; step(); out_rinc = 0;
    n_checks++;
    if (out_rempty !== 1'b1 || out_count !== 7'd0) begin
      n_fail++; $display("FAIL single_pop: got empty=%b count=%0d, want 1 0", out_rempty, out_count);
    end
  endtask

  task automatic test_burst();
    logic [OW-1:0] exp2 [8];
    exp2 = '{10'h010, 10'h111, 10'h212, 10'h313, 10'h020, 10'h121, 10'h222, 10'h323};
    do_reset();
    core_pkt_valid = 4'hF; core_pkt_data = 32'h1312_1110;
    step();
    core_pkt_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (out_count !== 7'(k)) begin
        n_fail++; $display("FAIL burst_count[%0d]: got %0d, want %0d", k, out_count, k);
      end
    end
    core_pkt_valid = 4'hF; core_pkt_data = 32'h2322_2120;
    step();
    core_pkt_valid = '0;
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (out_rdata !== exp2[k]) begin
        n_fail++; $display("FAIL burst_order[%0d]: got %h, want %h", k, out_rdata, exp2[k]);
      end
      out_rinc = 1; step();
    end
    out_rinc = 0;
    n_checks++;
    if (out_rempty !== 1'b1) begin
      n_fail++; $display("FAIL burst_drained: got empty=%b, want 1", out_rempty);
    end
  endtask

  task automatic test_fair_overflow();
    do_reset();
    // One core-0 packet moves the search start to core 1.
    core_pkt_valid = 4'b0001; core_pkt_data = 32'h0000_0077;
    step(); core_pkt_valid = '0; step(); step();
    for (int c = 0; c < 5; c++) begin
      core_pkt_valid = 4'hF; core_pkt_data = $urandom;
      step();
      n_checks++;
      if (ch_overflow[1] !== 1'b0 || {tick_out, tick_overrun, ch_overflow, out_rempty, out_count} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL fair_stream[%0d]: got ctl=%h, want ctl=%h (core1 must not overflow)",
                 c, {tick_out, tick_overrun, ch_overflow, out_rempty, out_count}, exp_ctl());
      end
    end
    core_pkt_valid = '0;
    for (int c = 0; c < 8; c++) step();
    clear_errors = 1; step(); clear_errors = 0;
    // Stream core 0 until the merged FIFO reports full.
    core_pkt_valid = 4'b0001;
    for (int n = 0; n < 200 && out_count !== 7'd64; n++) begin
      core_pkt_data = $urandom; step();
    end
    core_pkt_valid = '0;
    n_checks++;
    if (out_count !== 7'd64) begin
      n_fail++; $display("FAIL fill_merged: got count=%0d, want 64", out_count);
    end
    for (int c = 1; c <= 5; c++) begin
      core_pkt_valid = 4'b0010; core_pkt_data = {16'h0, 8'(8'hC0 + c), 8'h00};
      step();
      if (c >= 4) begin
        n_checks++;
        if (ch_overflow[1] !== (c == 5) || {tick_out, tick_overrun, ch_overflow, out_rempty, out_count} !== exp_ctl()) begin
          n_fail++;
          $display("FAIL core1_overflow[%0d]: got ovf=%b ctl=%h, want ovf1=%0d ctl=%h",
                   c, ch_overflow, {tick_out, tick_overrun, ch_overflow, out_rempty, out_count}, (c == 5), exp_ctl());
        end
      end
    end
    core_pkt_valid = '0;
    clear_errors = 1; step(); clear_errors = 0;
    n_checks++;
    if (ch_overflow !== '0 || out_count !== 7'd64) begin
      n_fail++; $display("FAIL clear_overflow: got ovf=%b count=%0d, want 0 64", ch_overflow, out_count);
    end
  endtask

  task automatic test_full_wrap();
    for (int c = 0; c < 160; c++) begin
      core_pkt_valid = (c < 20) ? 4'hF : 4'($urandom);
      core_pkt_data  = $urandom;
      out_rinc       = (c < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      step();
      n_checks++;
      if ({tick_out, tick_overrun, ch_overflow, out_rempty, out_count} !== exp_ctl() ||
          (m_out.size() > 0 && out_rdata !== exp_head()) ||
          (c >= 1 && c < 20 && out_count !== 7'd63)) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got ctl=%h rdata=%h, want ctl=%h rdata=%h",
                 c, {tick_out, tick_overrun, ch_overflow, out_rempty, out_count}, out_rdata, exp_ctl(), exp_head());
      end
    end
    // Asynchronous reset in the middle of a cycle with traffic still flowing.
    core_pkt_valid = 4'hF; out_rinc = 0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({tick_out, tick_overrun, ch_overflow, out_rempty, out_count} !== RST_CTL || out_rdata !== '0) begin
      n_fail++;
      $display("FAIL midstream_reset: got ctl=%h rdata=%h, want ctl=%h rdata=0",
               {tick_out, tick_overrun, ch_overflow, out_rempty, out_count}, out_rdata, RST_CTL);
    end
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_tick();
    do_reset();
    tick_in = 1; step(); tick_in = 0;
    n_checks++;
    if (tick_out !== 1'b0) begin n_fail++; $display("FAIL tick_early: got %b, want 0", tick_out); end
    step();
    n_checks++;
    if (tick_out !== 1'b1) begin n_fail++; $display("FAIL tick_latency2: got %b, want 1", tick_out); end
    step();
    n_checks++;
    if (tick_out !== 1'b0 || tick_overrun !== 1'b0) begin
      n_fail++; $display("FAIL tick_one_cycle: got tick=%b ovr=%b, want 0 0", tick_out, tick_overrun);
    end
    core_tick_ready = 4'b1011;
    tick_in = 1; step(); tick_in = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (tick_out !== 1'b0) begin n_fail++; $display("FAIL tick_held[%0d]: got %b, want 0", c, tick_out); end
    end
    core_tick_ready = 4'hF;
    step();
    n_checks++;
    if (tick_out !== 1'b1) begin n_fail++; $display("FAIL tick_release: got %b, want 1", tick_out); end
    step();
    n_checks++;
    if (tick_out !== 1'b0) begin n_fail++; $display("FAIL tick_release_end: got %b, want 0", tick_out); end
  endtask

  task automatic test_overrun();
    int pulses;
    do_reset();
    core_tick_ready = 4'b1011;
    tick_in = 1; step(); step(); tick_in = 0;
    n_checks++;
    if (tick_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, want 1", tick_overrun); end
    core_tick_ready = 4'hF;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin step(); if (tick_out === 1'b1) pulses++; end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL overrun_single_tick: got %0d pulses, want 1", pulses); end
    clear_errors = 1; step(); clear_errors = 0;
    core_tick_ready = 4'b1011;
    tick_in = 1; step();
    clear_errors = 1; step();
    tick_in = 0; clear_errors = 0;
    n_checks++;
    if (tick_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set_wins: got %b, want 1", tick_overrun); end
    clear_errors = 1; step(); clear_errors = 0;
    n_checks++;
    if (tick_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b, want 0", tick_overrun); end
    core_tick_ready = 4'hF;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      core_pkt_valid  = 4'($urandom);
      core_pkt_data   = $urandom;
      core_tick_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      tick_in         = ($urandom_range(0, 9) == 0);
      clear_errors    = ($urandom_range(0, 19) == 0);
      out_rinc        = $urandom_range(0, 1);
      step();
      n_checks++;
      if ({tick_out, tick_overrun, ch_overflow, out_rempty, out_count} !== exp_ctl() ||
          (m_out.size() > 0 && out_rdata !== exp_head())) begin
        n_fail++;
        $display("FAIL random[%0d]: got ctl=%h rdata=%h, want ctl=%h rdata=%h",
                 c, {tick_out, tick_overrun, ch_overflow, out_rempty, out_count}, out_rdata, exp_ctl(), exp_head());
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_burst();
    test_fair_overflow();
    test_full_wrap();
    test_tick();
    test_overrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "time limit");
  end

endmodule
